// File: rtl/sccb_cfg_sequencer_if.sv
// sccb_cfg_sequencer_if
// Groups every non-clock signal of the OV7670 register sequencer.
//   master modport : the sequencer (drives table index, engine controls,
//                    request ready and status)
//   slave modport  : the environment (register ROM, SCCB byte engine,
//                    runtime requester and status consumer)
// Signals:
//   tbl_idx/tbl_entry          table index out, {reg_addr,reg_data} back
//   eng_start/eng_stop         one-cycle pulses to the byte engine
//   eng_wr_data                byte handed to the engine
//   eng_ack                    [1] ninth-bit tick, [0] 1=ACK 0=NACK
//   eng_idle                   engine is in its idle state
//   req_valid/req_ready        runtime single-register write handshake
//   req_addr/req_data          runtime register address and data
//   cfg_done/busy/err/nack_cnt status
interface sccb_cfg_sequencer_if;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_entry;
  logic        eng_start;
  logic        eng_stop;
  logic [7:0]  eng_wr_data;
  logic [1:0]  eng_ack;
  logic        eng_idle;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [7:0]  req_data;
  logic        cfg_done;
  logic        busy;
  logic        err;
  logic [7:0]  nack_cnt;

  modport master (
    output tbl_idx, eng_start, eng_stop, eng_wr_data, req_ready,
           cfg_done, busy, err, nack_cnt,
    input  tbl_entry, eng_ack, eng_idle, req_valid, req_addr, req_data
  );

  modport slave (
    input  tbl_idx, eng_start, eng_stop, eng_wr_data, req_ready,
           cfg_done, busy, err, nack_cnt,
    output tbl_entry, eng_ack, eng_idle, req_valid, req_addr, req_data
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer
// Walks a {reg_addr,reg_data} table after power-up and programs each entry
// into the OV7670 through the SCCB byte engine as a 3-byte write
// (slave ID, register address, register data). Inserts idle gaps between
// transactions, retries NACKed entries, and afterwards serves single
// register writes from a valid/ready request port.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (shared with the byte engine)
//   bus    sccb_cfg_sequencer_if.master (table, engine, request, status)
module sccb_cfg_sequencer #(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [7:0]  SLAVE_WR    = 8'h42,
  parameter logic [27:0] POWERUP_CYC = 28'd67108864,
  parameter logic [27:0] GAP_CYC     = 28'd65536,
  parameter logic [27:0] POST_CYC    = 28'd67108864,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  sccb_cfg_sequencer_if.master bus
);

  localparam logic [7:0] LAST_IDX  = 8'(NUM_REGS - 1);
  localparam logic [7:0] END_IDX   = 8'(NUM_REGS);
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_START,
    S_ADDR,
    S_DATA,
    S_STOP,
    S_GAP,
    S_READY
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  tbl_idx_q, tbl_idx_d;
  logic [7:0]  nack_cnt_q, nack_cnt_d;
  logic [7:0]  req_addr_q, req_addr_d;
  logic [7:0]  req_data_q, req_data_d;
  logic        cfg_done_q, cfg_done_d;
  logic        err_q, err_d;
  logic        runtime_q, runtime_d;
  logic        post_q, post_d;

  logic        eng_start, eng_stop, req_ready;
  logic [7:0]  eng_wr_data;
  logic [7:0]  cur_addr, cur_data;
  logic [27:0] gap_len;
  logic        ack_ok, ack_nack, last_entry, soft_reset, in_xfer;

  // Byte source: the latched request once in runtime mode, else the ROM.
  assign cur_addr   = runtime_q ? req_addr_q : bus.tbl_entry[15:8];
  assign cur_data   = runtime_q ? req_data_q : bus.tbl_entry[7:0];
  assign ack_ok     = (bus.eng_ack == 2'b11);
  assign ack_nack   = (bus.eng_ack == 2'b10);
  assign in_xfer    = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_STOP);
  assign last_entry = !runtime_q && (tbl_idx_q == LAST_IDX);
  // COM7 with bit 7 set resets the sensor; it needs the long settle time.
  assign soft_reset = !runtime_q && (cur_addr == 8'h12) && cur_data[7];
  assign gap_len    = post_q ? POST_CYC : GAP_CYC;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    tbl_idx_d   = tbl_idx_q;
    nack_cnt_d  = nack_cnt_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    cfg_done_d  = cfg_done_q;
    err_d       = err_q;
    runtime_d   = runtime_q;
    post_d      = post_q;
    eng_start   = 1'b0;
    eng_stop    = 1'b0;
    eng_wr_data = 8'h00;
    req_ready   = 1'b0;

    unique case (state_q)
      S_POWERUP: begin
        if (cnt_q == POWERUP_CYC - 28'd1) state_d = S_START;
        else                              cnt_d   = cnt_q + 28'd1;
      end
      S_START: begin
        if (bus.eng_idle) begin
          eng_start   = 1'b1;
          eng_wr_data = SLAVE_WR;
          state_d     = S_ADDR;
        end
      end
      // The next byte is presented in the very cycle the previous one is
      // acknowledged, so these outputs depend on eng_ack combinationally.
      S_ADDR: begin
        if (ack_ok) begin
          eng_wr_data = cur_addr;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (ack_ok) begin
          eng_wr_data = cur_data;
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        if (ack_ok) begin
          eng_stop = 1'b1;
          state_d  = S_GAP;
          retry_d  = 8'd0;
          post_d   = soft_reset || last_entry;
          if (!runtime_q) tbl_idx_d = tbl_idx_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == gap_len - 28'd1) begin
          if (runtime_q)                   state_d = S_READY;
          else if (tbl_idx_q != END_IDX)   state_d = S_START;
          else begin
            cfg_done_d = 1'b1;
            state_d    = S_READY;
          end
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end
      S_READY: begin
        req_ready = bus.eng_idle;
        if (bus.req_valid && bus.eng_idle) begin
          req_addr_d = bus.req_addr;
          req_data_d = bus.req_data;
          runtime_d  = 1'b1;
          state_d    = S_START;
        end
      end
      default: state_d = S_POWERUP;
    endcase

    // A NACK on any byte aborts the transaction; either re-send the same
    // entry or, once retries are exhausted, flag and skip it.
    if (in_xfer && ack_nack) begin
      eng_stop = 1'b1;
      state_d  = S_GAP;
      if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
      if (retry_q < RETRY_LIM) begin
        retry_d = retry_q + 8'd1;
        post_d  = 1'b0;
      end else begin
        err_d   = 1'b1;
        retry_d = 8'd0;
        post_d  = last_entry;
        if (!runtime_q) tbl_idx_d = tbl_idx_q + 8'd1;
      end
    end

    // Every delay starts from zero in the state it times.
    if (state_d != state_q) cnt_d = 28'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_POWERUP;
      cnt_q      <= 28'd0;
      retry_q    <= 8'd0;
      tbl_idx_q  <= 8'd0;
      nack_cnt_q <= 8'd0;
      req_addr_q <= 8'd0;
      req_data_q <= 8'd0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
      runtime_q  <= 1'b0;
      post_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      tbl_idx_q  <= tbl_idx_d;
      nack_cnt_q <= nack_cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      runtime_q  <= runtime_d;
      post_q     <= post_d;
    end
  end

  assign bus.tbl_idx     = tbl_idx_q;
  assign bus.eng_start   = eng_start;
  assign bus.eng_stop    = eng_stop;
  assign bus.eng_wr_data = eng_wr_data;
  assign bus.req_ready   = req_ready;
  assign bus.cfg_done    = cfg_done_q;
  assign bus.busy        = (state_q != S_READY);
  assign bus.err         = err_q;
  assign bus.nack_cnt    = nack_cnt_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb_sccb_cfg_sequencer
// Drives sccb_cfg_sequencer with a behavioural SCCB byte engine and a
// 4-entry register ROM {1280,1204,1520,8C03}. Expected 3-byte transactions
// are queued when a scenario is set up and compared when the engine sees
// the closing stop.
module tb_sccb_cfg_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  sccb_cfg_sequencer_if bus_if ();

  sccb_cfg_sequencer #(
    .NUM_REGS    (4),
    .SLAVE_WR    (8'h42),
    .POWERUP_CYC (28'd100),
    .GAP_CYC     (28'd10),
    .POST_CYC    (28'd50),
    .MAX_RETRY   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Register table seen by the sequencer
  function automatic logic [15:0] romEntry(input logic [7:0] idx);
    case (idx)
      8'd0:    romEntry = 16'h1280;
      8'd1:    romEntry = 16'h1204;
      8'd2:    romEntry = 16'h1520;
      8'd3:    romEntry = 16'h8C03;
      default: romEntry = 16'h0000;
    endcase
  endfunction

  assign bus_if.tbl_entry = romEntry(bus_if.tbl_idx);

  int vectors = 0;
  int errors  = 0;
  logic [23:0] expQ[$];

  // Scenario controls, written by the main process only
  int strayReq  = 0;
  int nackIdx   = -1;
  int nackTick  = 0;
  int nackLimit = 0;

  // Engine / monitor observations, written by the engine process only
  int cyc;
  int firstStart, lastStop, nackStop, retryGap, gapIdx, attempts;
  int doneCyc, acceptCyc, readyCyc, readyEarly, strayStop, bothHigh;
  int gaps[8];
  int tick, waitCnt, idleDelay, curIdx, nackIssued, strayDone;
  logic busyPrev, engBusy, attemptNack, entry3Data;
  logic [23:0] obs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural byte engine plus monitor: observe at the falling edge,
  // apply the next engine inputs just after the rising edge.
  initial begin : engine
    logic [1:0] nextAck, curAck;
    logic       nextIdle, isNack;
    bus_if.eng_ack  = 2'b00;
    bus_if.eng_idle = 1'b1;
    forever begin
      @(negedge clk);
      nextAck  = 2'b00;
      nextIdle = 1'b1;
      if (!rst_n) begin
        firstStart = -1; lastStop = -1; nackStop = -1; retryGap = -1;
        gapIdx = 0; attempts = 0; doneCyc = -1; acceptCyc = -1; readyCyc = -1;
        readyEarly = 0; strayStop = 0; bothHigh = 0; busyPrev = 1'b1;
        engBusy = 1'b0; attemptNack = 1'b0; entry3Data = 1'b0; obs = 24'h0;
        tick = 0; waitCnt = 0; idleDelay = 0; curIdx = -1; nackIssued = 0; strayDone = 0;
        for (int i = 0; i < 8; i++) gaps[i] = 0;
      end else begin
        curAck = bus_if.eng_ack;
        if (bus_if.eng_start && bus_if.eng_stop) bothHigh++;
        if (curAck[1] && engBusy) begin
          if (!curAck[0]) begin
            checkOutput("stop_on_nack", 32'(bus_if.eng_stop), 1);
            attemptNack = 1'b1;
          end else if (tick == 0) begin
            obs[15:8] = bus_if.eng_wr_data;
            if (curIdx == 2) entry3Data = 1'b1;
          end else if (tick == 1) begin
            obs[7:0] = bus_if.eng_wr_data;
          end else begin
            checkOutput("stop_on_ack", 32'(bus_if.eng_stop), 1);
          end
          tick++;
        end
        if (bus_if.eng_stop) begin
          if (engBusy) begin
            lastStop = cyc;
            if (attemptNack) begin
              if (nackStop < 0) nackStop = cyc;
            end else if (expQ.size() == 0) begin
              checkOutput("txn_extra", 32'(obs), 0);
            end else begin
              checkOutput("txn", 32'(obs), 32'(expQ.pop_front()));
            end
            engBusy   = 1'b0;
            idleDelay = 2;
          end else begin
            strayStop++;
          end
        end
        if (bus_if.eng_start) begin
          attempts++;
          if (firstStart < 0) firstStart = cyc;
          if (lastStop >= 0 && gapIdx < 8) begin
            gaps[gapIdx] = cyc - lastStop - 1;
            gapIdx++;
          end
          if (nackStop >= 0 && retryGap < 0) retryGap = cyc - nackStop - 1;
          obs         = {bus_if.eng_wr_data, 16'h0000};
          engBusy     = 1'b1;
          attemptNack = 1'b0;
          tick        = 0;
          waitCnt     = 3;
          curIdx      = int'(bus_if.tbl_idx);
        end
        if (bus_if.cfg_done && doneCyc < 0) doneCyc = cyc;
        if (bus_if.req_ready && !bus_if.cfg_done) readyEarly++;
        if (bus_if.req_ready && bus_if.req_valid) acceptCyc = cyc;
        if (!bus_if.busy && busyPrev) readyCyc = cyc;
        busyPrev = bus_if.busy;

        if (engBusy) begin
          nextIdle = 1'b0;
          if (waitCnt > 0) begin
            waitCnt--;
          end else begin
            isNack = (nackIssued < nackLimit) && (curIdx == nackIdx) && (tick == nackTick);
            if (isNack) nackIssued++;
            nextAck = {1'b1, ~isNack};
            waitCnt = 3;
          end
        end else if (idleDelay > 0) begin
          idleDelay--;
          nextIdle = 1'b0;
        end else if (strayDone < strayReq) begin
          strayDone++;
          nextAck = 2'b10;
        end
      end
      @(posedge clk);
      #1;
      bus_if.eng_ack  = nextAck;
      bus_if.eng_idle = nextIdle;
    end
  end

  task automatic applyReset();
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = 8'h00;
    bus_if.req_data  = 8'h00;
    strayReq  = 0;
    nackLimit = 0;
    nackIdx   = -1;
    expQ.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sets up one scenario and queues the transactions it should produce
  task automatic applyStimulus(input int kind);
    for (int i = 0; i < 4; i++)
      if (!(kind == 2 && i == 2)) expQ.push_back({8'h42, romEntry(8'(i))});
    case (kind)
      0: strayReq = 2;
      1: begin nackIdx = 1; nackTick = 2; nackLimit = 1;   end
      2: begin nackIdx = 2; nackTick = 1; nackLimit = 100; end
      3: begin
        expQ.push_back(24'h421105);
        bus_if.req_addr  = 8'h11;
        bus_if.req_data  = 8'h05;
        bus_if.req_valid = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!bus_if.cfg_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    checkOutput("cfg_done", 32'(bus_if.cfg_done), 1);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;

    // All entries acknowledged, stray ticks in POWERUP and READY
    applyReset();
    applyStimulus(0);
    waitDone(3000);
    checkOutput("first_start", 32'(firstStart), 100);
    checkOutput("gap_after_com7", 32'(gaps[0]), 50);
    checkOutput("gap_2", 32'(gaps[1]), 10);
    checkOutput("gap_3", 32'(gaps[2]), 10);
    checkOutput("done_after_stop", 32'(doneCyc - lastStop - 1), 50);
    checkOutput("nack_cnt_a", 32'(bus_if.nack_cnt), 0);
    checkOutput("err_a", 32'(bus_if.err), 0);
    checkOutput("tbl_idx_end", 32'(bus_if.tbl_idx), 4);
    checkOutput("attempts_a", 32'(attempts), 4);
    checkOutput("queue_a", 32'(expQ.size()), 0);
    strayReq = strayReq + 2;
    repeat (10) @(negedge clk);
    checkOutput("ready_stray_nack", 32'(bus_if.nack_cnt), 0);
    checkOutput("ready_stray_busy", 32'(bus_if.busy), 0);
    checkOutput("stray_stop", 32'(strayStop), 0);
    checkOutput("start_stop_overlap", 32'(bothHigh), 0);

    // Single NACK on the data byte of entry 2
    applyReset();
    applyStimulus(1);
    waitDone(3000);
    checkOutput("nack_cnt_b", 32'(bus_if.nack_cnt), 1);
    checkOutput("err_b", 32'(bus_if.err), 0);
    checkOutput("attempts_b", 32'(attempts), 5);
    checkOutput("retry_gap", 32'(retryGap), 10);
    checkOutput("queue_b", 32'(expQ.size()), 0);

    // Persistent NACK on entry 3: four attempts then skipped
    applyReset();
    applyStimulus(2);
    waitDone(3000);
    checkOutput("err_c", 32'(bus_if.err), 1);
    checkOutput("nack_cnt_c", 32'(bus_if.nack_cnt), 4);
    checkOutput("attempts_c", 32'(attempts), 7);
    checkOutput("tbl_idx_c", 32'(bus_if.tbl_idx), 4);
    checkOutput("queue_c", 32'(expQ.size()), 0);

    // Runtime write held from the start of the table walk
    applyReset();
    applyStimulus(3);
    n = 0;
    while (acceptCyc < 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1 bus_if.req_valid = 1'b0;
    checkOutput("accept_first_ready", 32'(acceptCyc - doneCyc), 0);
    checkOutput("ready_during_walk", 32'(readyEarly), 0);
    @(negedge clk);
    checkOutput("busy_runtime", 32'(bus_if.busy), 1);
    n = 0;
    while (readyCyc <= acceptCyc && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("runtime_ready_gap", 32'(readyCyc - lastStop - 1), 10);
    checkOutput("queue_d", 32'(expQ.size()), 0);
    checkOutput("err_d", 32'(bus_if.err), 0);

    // Reset in the middle of entry 3 DATA phase
    applyReset();
    applyStimulus(4);
    n = 0;
    while (!entry3Data && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_entry3_data", 32'(entry3Data), 1);
    @(negedge clk);
    checkOutput("tbl_idx_pre_reset", 32'(bus_if.tbl_idx), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                32'({bus_if.eng_start, bus_if.eng_stop, bus_if.eng_wr_data, bus_if.tbl_idx,
                     bus_if.cfg_done, bus_if.busy, bus_if.err, bus_if.nack_cnt, bus_if.req_ready}),
                32'({1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}));
    repeat (3) @(negedge clk);
    expQ.delete();
    rst_n = 1'b1;
    applyStimulus(4);
    waitDone(3000);
    checkOutput("first_start_after_reset", 32'(firstStart), 100);
    checkOutput("tbl_idx_e", 32'(bus_if.tbl_idx), 4);
    checkOutput("queue_e", 32'(expQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
Name: sccb_cfg_sequencer

Overview:
- Table-driven controller that sequences the SCCB byte engine (i2c_top, freq 100_000) to program OV7670 registers after power-up.
- Walks a register table of {addr,data} entries, one 3-byte write per entry (slave ID, reg address, reg data), with inter-transaction delays, NACK retry and a runtime single-register write port.
- Sits between the camera top level and i2c_top. Asserts cfg_done to release the pixel-capture path.

Parameters:
- NUM_REGS, 4, number of table entries (1..255).
- SLAVE_WR, 8'h42, SCCB write slave ID.
- POWERUP_CYC, 28'd67108864, idle cycles after reset before the first transaction.
- GAP_CYC, 28'd65536, idle cycles between transactions.
- POST_CYC, 28'd67108864, idle cycles after a soft-reset entry and after the last entry.
- MAX_RETRY, 3, retries per entry after NACK before skipping it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- tbl_idx  out  8  current table index to external ROM
- tbl_entry  in  16  {reg_addr,reg_data} for tbl_idx; combinational, valid in the same cycle
- eng_start  out  1  one-cycle start pulse to byte engine
- eng_stop  out  1  one-cycle stop pulse to byte engine
- eng_wr_data  out  8  byte to engine; meaningful only in eng_start or accepted-ack cycles, 0 otherwise
- eng_ack  in  2  [1] tick at 9th bit, [0] 1=ACK / 0=NACK
- eng_idle  in  1  engine state==0
- req_valid  in  1  runtime write request
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  8  runtime register address
- req_data  in  8  runtime register data
- cfg_done  out  1  table fully processed; sticky until reset
- busy  out  1  state != READY
- err  out  1  sticky: some entry or request exhausted its retries
- nack_cnt  out  8  total NACKs seen, saturating at 255

Behaviour:
- Reset is asynchronous; the engine shares rst_n. Reset values: state=POWERUP, eng_start=0, eng_stop=0, eng_wr_data=0, tbl_idx=0, cfg_done=0, busy=1, err=0, nack_cnt=0, req_ready=0, delay counter=0, retry=0. Reset mid-transaction aborts with no stop issued and restarts from POWERUP.
- Delay counter is 28 bits, cleared on every state entry.
- States and transitions:
  - POWERUP: count to POWERUP_CYC-1, then go to START.
  - START: wait for eng_idle. When idle, for one cycle drive eng_start=1 and eng_wr_data=SLAVE_WR, then go to ADDR.
  - ADDR: on eng_ack==2'b11, drive eng_wr_data=addr byte for that cycle and go to DATA.
  - DATA: on eng_ack==2'b11, drive eng_wr_data=data byte for that cycle and go to STOP.
  - STOP: on eng_ack==2'b11, pulse eng_stop and go to GAP. The entry is complete: tbl_idx++ (table mode), retry=0.
  - GAP: count the selected delay, then go to the next state. Delay selection:
    - POST_CYC if the completed entry had addr 8'h12 with data[7]=1 (COM7 soft reset), or if it was the last entry.
    - GAP_CYC otherwise.
  - Next state from GAP:
    - If table entries remain, go to START.
    - If the table is finished and cfg_done is not yet set, set cfg_done=1 at the end of the POST delay and go to READY.
    - If in runtime mode, go to READY.
  - READY: req_ready = eng_idle. On req_valid&req_ready, latch req_addr/req_data and go to START in runtime mode. The byte source is the latched pair, not the table.
- NACK: eng_ack==2'b10 in ADDR, DATA or STOP:
  - Pulse eng_stop the same cycle and increment nack_cnt (saturating).
  - If retry<MAX_RETRY: retry++ and go to GAP, re-sending the same entry.
  - Otherwise: set err=1, skip the entry (tbl_idx++, or drop the request), retry=0, and go to GAP.
- eng_ack[1] ticks in any other state are ignored.
- tbl_idx stops at NUM_REGS once done and is never driven beyond it.
- req_valid during table walk is not accepted (req_ready=0); the request waits.
- eng_start and eng_stop are never high in the same cycle.

Test Plan (POWERUP_CYC=100, GAP_CYC=10, POST_CYC=50, behavioral engine model, table {1280,1204,1520,8C03}):
- All ACK:
  - eng_start first pulses 100 cycles after reset release.
  - 4 transactions carry bytes 42/12/80, 42/12/04, 42/15/20, 42/8C/03.
  - Gap after 12_80 is 50 cycles, then 10, 10.
  - cfg_done rises 50 cycles after the final stop; nack_cnt=0, err=0.
- Single NACK on the data byte of entry 2: eng_stop pulses in the same cycle, entry 2 is re-sent after a 10-cycle gap, nack_cnt=1, err=0, cfg_done eventually 1.
- Persistent NACK on entry 3: 4 attempts, then skip; entry 4 is still sent; err=1, nack_cnt=4, cfg_done=1.
- Runtime write:
  - req_valid with 11/05 held during the table walk gives req_ready=0 until READY.
  - It is then accepted in 1 cycle and bytes 42/11/05 are sent.
  - busy=1 during the transaction, back to READY after a 10-cycle gap.
- rst_n asserted in the middle of the entry-3 DATA phase: all outputs return to reset values asynchronously, tbl_idx=0, and the sequence restarts with the 100-cycle power-up.
- ack tick while in POWERUP or READY: ignored, no state change, nack_cnt unchanged.
